// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues imem requests, presents words to decode.
// Optional perf counters (fetch_cnt/stall_cnt) enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic [1:0]        dbg_state
);

  // Handshakes: an imem transfer completes on an edge where imem_req=1 and
  // imem_ready=1; imem_addr is held while imem_req=1 and imem_ready=0. Decode
  // takes the presented word on an edge where out_valid=1 and stall=0.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_flush_addr;
  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_pc;
  logic [ADDR_W-1:0] w_redir_pc;

  assign w_redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_flush_addr <= RESET_PC;
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_pc     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            r_pc        <= w_redir_pc;
            r_out_valid <= 1'b0;
          end
          r_state <= FETCH;
        end
        FETCH: begin
          if (redirect_valid) begin
            r_pc        <= w_redir_pc;
            r_out_valid <= 1'b0;
            if (imem_ready) begin
              r_state <= FETCH;
            end else begin
              // The in-flight request must still be completed at its old address.
              r_flush_addr <= r_pc;
              r_state      <= FLUSH;
            end
          end else if (imem_ready) begin
            r_out_instr <= imem_rdata;
            r_out_pc    <= r_pc;
            r_out_valid <= 1'b1;
            r_pc        <= r_pc + ADDR_W'(4);
            r_state     <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            r_pc        <= w_redir_pc;
            r_out_valid <= 1'b0;
            r_state     <= FETCH;
          end else if (!stall) begin
            r_out_valid <= 1'b0;
            r_state     <= FETCH;
          end
        end
        FLUSH: begin
          if (redirect_valid) begin
            r_pc        <= w_redir_pc;
            r_out_valid <= 1'b0;
          end else if (imem_ready) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (r_state == HOLD) begin
      if (stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else if (!redirect_valid) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

  // Decoded from state so an asynchronous reset drops the request immediately.
  assign imem_req  = (r_state == FETCH) || (r_state == FLUSH);
  assign imem_addr = (r_state == FLUSH) ? r_flush_addr : r_pc;
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_pc    = r_out_pc;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: two instances (RESET_PC=0 and RESET_PC=0xFFFFFFFC)
// share stimulus; each memory model returns the word index of the requested address.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ready = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        a_req, b_req;
  logic [31:0] a_addr, b_addr, a_rdata, b_rdata;
  logic        a_valid, b_valid;
  logic [31:0] a_instr, b_instr, a_pc, b_pc;
  logic [1:0]  a_state, b_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] a_fcnt, a_scnt, b_fcnt, b_scnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign a_rdata = {2'b00, a_addr[31:2]};
  assign b_rdata = {2'b00, b_addr[31:2]};

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_a (
    .clk(clk), .reset(reset),
    .imem_req(a_req), .imem_addr(a_addr), .imem_ready(imem_ready), .imem_rdata(a_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(a_valid), .out_instr(a_instr), .out_pc(a_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(a_fcnt), .stall_cnt(a_scnt),
`endif
    .dbg_state(a_state)
  );

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_b (
    .clk(clk), .reset(reset),
    .imem_req(b_req), .imem_addr(b_addr), .imem_ready(imem_ready), .imem_rdata(b_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(b_valid), .out_instr(b_instr), .out_pc(b_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt(b_fcnt), .stall_cnt(b_scnt),
`endif
    .dbg_state(b_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_req", {31'd0, a_req}, 32'd0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_pc", a_pc, 32'h0);
    chk("rst_state", {30'd0, a_state}, 32'd0);
    chk("rst_addr_b", b_addr, 32'hFFFF_FFFC);

    // Sequential fetch, fast memory, no stall
    imem_ready = 1'b1;
    step();
    chk("seq_req_first", {31'd0, a_req}, 32'd1);
    chk("seq_state_fetch", {30'd0, a_state}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", a_addr, 32'(i * 4));
      step();
      chk("seq_valid_hi", {31'd0, a_valid}, 32'd1);
      chk("seq_out_pc", a_pc, 32'(i * 4));
      chk("seq_out_instr", a_instr, 32'(i));
      chk("seq_req_hold", {31'd0, a_req}, 32'd0);
      step();
      chk("seq_valid_lo", {31'd0, a_valid}, 32'd0);
    end

    // Slow memory: ready arrives after 3 waiting cycles
    do_reset();
    step();
    for (int i = 0; i < 3; i++) begin
      chk("slow_req", {31'd0, a_req}, 32'd1);
      chk("slow_addr", a_addr, 32'h0);
      chk("slow_valid", {31'd0, a_valid}, 32'd0);
      step();
    end
    imem_ready = 1'b1;
    step();
    chk("slow_valid_rise", {31'd0, a_valid}, 32'd1);
    chk("slow_out_pc", a_pc, 32'h0);
    imem_ready = 1'b0;

    // Stall in HOLD for 5 cycles
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'd0, a_valid}, 32'd1);
      chk("stall_pc", a_pc, 32'h0);
      chk("stall_instr", a_instr, 32'h0);
      chk("stall_req", {31'd0, a_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("stall_rel_valid", {31'd0, a_valid}, 32'd0);
    chk("stall_rel_addr", a_addr, 32'h4);
    imem_ready = 1'b1;
    step();
    chk("stall_next_pc", a_pc, 32'h4);
    chk("stall_next_instr", a_instr, 32'h1);

    // Redirect while holding an instruction
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    chk("rdh_valid", {31'd0, a_valid}, 32'd0);
    chk("rdh_addr", a_addr, 32'h40);
    chk("rdh_state", {30'd0, a_state}, 32'd1);
    redirect_valid = 1'b0;
    imem_ready = 1'b1;
    step();
    chk("rdh_out_pc", a_pc, 32'h40);
    chk("rdh_out_instr", a_instr, 32'h10);

    // Redirect while a request is outstanding: go to 0x8 first, then 0x103
    imem_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    step();
    chk("rdf_pre_addr", a_addr, 32'h8);
    redirect_pc = 32'h103;
    step();
    chk("rdf_state", {30'd0, a_state}, 32'd3);
    chk("rdf_req", {31'd0, a_req}, 32'd1);
    chk("rdf_addr", a_addr, 32'h8);
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rdf_hold_addr", a_addr, 32'h8);
      chk("rdf_no_valid", {31'd0, a_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    step();
    chk("rdf_exit_addr", a_addr, 32'h100);
    chk("rdf_exit_valid", {31'd0, a_valid}, 32'd0);
    step();
    chk("rdf_out_pc", a_pc, 32'h100);
    chk("rdf_out_instr", a_instr, 32'h40);

    // Redirect in FETCH with ready=1: returned data is discarded
    step();
    chk("rdr_addr", a_addr, 32'h104);
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    step();
    chk("rdr_state", {30'd0, a_state}, 32'd1);
    chk("rdr_new_addr", a_addr, 32'h20);
    chk("rdr_valid", {31'd0, a_valid}, 32'd0);
    redirect_valid = 1'b0;
    step();
    chk("rdr_out_pc", a_pc, 32'h20);
    chk("rdr_out_instr", a_instr, 32'h8);

    // PC wrap on the instance reset to 0xFFFFFFFC
    do_reset();
    imem_ready = 1'b1;
    step();
    chk("wrap_addr0", b_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_out_pc0", b_pc, 32'hFFFF_FFFC);
    chk("wrap_out_instr0", b_instr, 32'h3FFF_FFFF);
    step();
    chk("wrap_addr1", b_addr, 32'h0);
    step();
    chk("wrap_out_pc1", b_pc, 32'h0);

    // Asynchronous reset mid-request
    imem_ready = 1'b0;
    step();
    chk("arst_pre_req", {31'd0, a_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", {31'd0, a_req}, 32'd0);
    chk("arst_state", {30'd0, a_state}, 32'd0);
    chk("arst_addr_b", b_addr, 32'hFFFF_FFFC);
    @(posedge clk);
    #1 reset = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    // Counters: 4 fetches, 5 stall cycles
    do_reset();
    chk("cnt_rst_f", a_fcnt, 32'd0);
    chk("cnt_rst_s", a_scnt, 32'd0);
    imem_ready = 1'b1;
    step();
    step();
    stall = 1'b1;
    repeat (5) step();
    stall = 1'b0;
    repeat (7) step();
    chk("cnt_fetch", a_fcnt, 32'd4);
    chk("cnt_stall", a_scnt, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controller that sequences the instruction-fetch datapath. It owns the PC, issues requests to an instruction memory with a req/ready handshake, and presents each fetched instruction to decode with a valid/stall handshake. It also accepts PC redirects from branch/jump resolution, including redirects that arrive while a memory request is still outstanding.

Parameters:
ADDR_W, 32, PC and memory address width in bits.
RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request to instruction memory
imem_addr  output  ADDR_W  byte address of requested word
imem_ready  input  1  memory has data for the current request
imem_rdata  input  32  instruction word; valid only when imem_ready=1
stall  input  1  decode cannot accept the presented instruction
redirect_valid  input  1  load a new PC (branch/jump taken)
redirect_pc  input  ADDR_W  redirect target
out_valid  output  1  out_instr/out_pc hold a valid instruction
out_instr  output  32  fetched instruction
out_pc  output  ADDR_W  address of out_instr

Behaviour:
- Reset is asynchronous, active-high, on clk/reset. Reset state: state=IDLE, pc_reg=RESET_PC, imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- imem_addr always equals pc_reg, except in FLUSH, where it equals the held address of the outstanding request.
- imem_req=1 only in FETCH and FLUSH. It is decoded from the registered state.
- The memory contract requires imem_addr to remain stable while imem_req=1 and imem_ready=0.
- State IDLE: exits to FETCH unconditionally on the first edge after reset deassert. imem_req=0.
- State FETCH: imem_req=1. On an edge with imem_ready=1 and no redirect:
  - out_instr<=imem_rdata; out_pc<=pc_reg; out_valid<=1.
  - pc_reg<=pc_reg+4, modulo 2^ADDR_W.
  - Next state HOLD.
  - With imem_ready=0, remain in FETCH with all outputs stable.
- State HOLD: imem_req=0 and out_valid=1.
  - On an edge with stall=0: out_valid<=0, next state FETCH.
  - On an edge with stall=1: remain in HOLD; out_instr/out_pc unchanged.
- Redirect takes priority over all other events in every non-IDLE state.
  - pc_reg<=redirect_pc with bits [1:0] forced to 0.
  - out_valid<=0.
  - HOLD + redirect: next state FETCH; the held instruction is dropped.
  - FETCH + redirect + imem_ready=1: returned data is discarded; next state FETCH at the new PC.
  - FETCH + redirect + imem_ready=0: the old address is latched into flush_addr; next state FLUSH.
  - FLUSH + redirect: pc_reg is updated; remain in FLUSH.
  - IDLE + redirect: pc_reg is loaded; next state FETCH.
- State FLUSH: imem_req=1 and imem_addr=flush_addr.
  - On imem_ready=1: data is discarded; next state FETCH.
  - No out_valid is produced in FLUSH.
- Throughput: at most 1 instruction per 2 cycles. Latency is 1 cycle from imem_ready to out_valid.
- Reset mid-transaction: imem_req drops immediately (asynchronously). Any outstanding request is abandoned.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds output ports fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each HOLD exit with stall=0 and no redirect.
  - stall_cnt increments on each cycle in HOLD with stall=1.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters do not exist, and the rest of the behaviour is identical.

Test Plan:
- Sequential fetch: reset, imem_ready=1, stall=0, memory returns the word index -> imem_req first high 1 cycle after reset release; out_pc=0,4,8,12 with out_instr=0,1,2,3; out_valid pulses 1 cycle in every 2.
- Slow memory: imem_ready delayed 3 cycles -> imem_req=1 and imem_addr=0x0 stable for 3 cycles; out_valid rises the cycle after ready.
- Stall: stall=1 for 5 cycles in HOLD -> out_valid=1, out_instr/out_pc unchanged, imem_req=0 throughout; next fetch at +4 after release.
- Redirect in HOLD: redirect_pc=0x40 -> out_valid=0 next cycle; next imem_addr=0x40; out_pc=0x40 after completion.
- Redirect mid-request: in FETCH at 0x8, ready=0, redirect_pc=0x103 -> FLUSH; imem_addr held at 0x8 until ready; no out_valid; then imem_addr=0x100.
- Wrap and counters: RESET_PC=0xFFFFFFFC -> second fetch at 0x0. With FETCH_PERF_CNT_EN: 4 fetches and 5 stall cycles -> fetch_cnt=4, stall_cnt=5.
